// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// FSM state encoding and STATUS field positions.
package int_ctrl_pkg;

  localparam int unsigned ID_W = 5;

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_CLAIM  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int unsigned STATUS_INSVC_BIT = 31;
  localparam int unsigned STATUS_ID_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// MIO bus slave port of the interrupt controller register block.
interface int_ctrl_if;
  logic        sel_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output sel_i, output we_i, output addr_i, output wdata_i,
                  input rdata_o);
  modport slave  (input sel_i, input we_i, input addr_i, input wdata_i,
                  output rdata_o);
endinterface

// File: rtl/int_ctrl_sync_edge.sv
// Two-flop synchroniser for one asynchronous source, plus a single-cycle
// pulse on each rising edge of the synchronised value.
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_prev;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronised sources, edge/level pending latches,
// mask, fixed-priority selection and a single-level CPU request FSM.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [31:0] VEC_BASE  = 32'h1C09_0000,
  parameter int unsigned VEC_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src_i,
  int_ctrl_if.slave        bus,
  output logic             irq_o,
  output logic [31:0]      vec_o,
  input  logic             ack_i
);

  logic [N_SRC-1:0] w_level;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [ID_W-1:0]  w_sel;
  logic [ID_W-1:0]  r_active;
  logic             r_insvc;
  logic             r_irq;
  logic [31:0]      r_vec;
  logic [31:0]      w_vec;
  logic             w_wr;
  logic             w_eoi;
  logic             w_ack;
  logic [31:0]      w_pend32;
  logic [31:0]      w_mask32;
  logic [31:0]      w_mode32;
  logic             w_unused;
  state_t           r_state;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    sync_edge u_sync (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (src_i[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_req = r_pend & r_mask;
  assign w_wr  = bus.sel_i & bus.we_i;
  assign w_eoi = w_wr && (bus.addr_i == ADDR_CLAIM);
  assign w_ack = (r_state == ST_REQ) && ack_i;
  assign w_vec = VEC_BASE + (32'(w_sel) << VEC_SHIFT);

  always_comb begin
    w_sel = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (w_req[i-1]) w_sel = ID_W'(i - 1);
    end
  end

  // A fresh rising edge overrides both W1C and ack clears in the same cycle.
  always_comb begin
    w_w1c      = (w_wr && (bus.addr_i == ADDR_PEND)) ? bus.wdata_i[N_SRC-1:0] : '0;
    w_ack_clr  = '0;
    w_pend_nxt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_ack_clr[i]  = w_ack && (w_sel == ID_W'(i));
      w_pend_nxt[i] = r_mode[i] ? ((r_pend[i] & ~w_w1c[i] & ~w_ack_clr[i]) | w_rise[i])
                                : w_level[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_wr && (bus.addr_i == ADDR_MASK)) r_mask <= bus.wdata_i[N_SRC-1:0];
      if (w_wr && (bus.addr_i == ADDR_MODE)) r_mode <= bus.wdata_i[N_SRC-1:0];
    end
  end

  // vec tracks the current selection except while an interrupt is being taken/served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_vec    <= VEC_BASE;
      r_active <= '0;
      r_insvc  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vec <= w_vec;
          if (|w_req) begin
            r_state <= ST_REQ;
            r_irq   <= 1'b1;
          end else begin
            r_irq   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_i) begin
            r_state  <= ST_SERVICE;
            r_irq    <= 1'b0;
            r_active <= w_sel;
            r_insvc  <= 1'b1;
          end else if (!(|w_req)) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= w_vec;
          end else begin
            r_irq <= 1'b1;
            r_vec <= w_vec;
          end
        end
        ST_SERVICE: begin
          r_irq <= 1'b0;
          if (w_eoi && (bus.wdata_i[ID_W-1:0] == r_active)) begin
            r_state  <= ST_IDLE;
            r_insvc  <= 1'b0;
            r_active <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o = r_irq;
  assign vec_o = r_vec;

  always_comb begin
    w_pend32 = '0;
    w_mask32 = '0;
    w_mode32 = '0;
    w_pend32[N_SRC-1:0] = r_pend;
    w_mask32[N_SRC-1:0] = r_mask;
    w_mode32[N_SRC-1:0] = r_mode;
    bus.rdata_o = '0;
    case (bus.addr_i)
      ADDR_PEND:   bus.rdata_o = w_pend32;
      ADDR_MASK:   bus.rdata_o = w_mask32;
      ADDR_MODE:   bus.rdata_o = w_mode32;
      ADDR_CLAIM:  bus.rdata_o = 32'(w_sel);
      ADDR_STATUS: begin
        bus.rdata_o[STATUS_INSVC_BIT] = r_insvc;
        bus.rdata_o[STATUS_ID_LSB +: ID_W] = r_active;
      end
      default:     bus.rdata_o = '0;
    endcase
  end

  assign w_unused = ^bus.wdata_i;

endmodule
